keypad_scanner: RTL

- Drives a 4x4 matrix keypad (active-low rows and columns), scans it, debounces it, and decodes it into the key-event interface the countdown control logic consumes: keydown_num, keydown_start, keydown_clear, keydown_confirm and num.
- Guarantees at most one keydown output high at a time, glitch-free levels, and num stable whenever keydown_num is high.
- Sits between the board keypad pins and the countdown logic, in the same clk domain.

---
 rtl/countdown_pkg.sv | 26 ++
 rtl/keypad_debounce.sv | 59 +++++
 rtl/keypad_scanner.sv | 134 +++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared key-code definitions for the keypad front end and the countdown control logic.
package countdown_pkg;

    typedef logic [4:0] key_code_t;

    localparam key_code_t KEY_START   = 5'd10;
    localparam key_code_t KEY_CLEAR   = 5'd11;
    localparam key_code_t KEY_CONFIRM = 5'd12;
    localparam key_code_t KEY_NONE    = 5'd31;

    localparam int SCAN_DIV_DEFAULT        = 1000;
    localparam int DEBOUNCE_FRAMES_DEFAULT = 8;

    // Indexed [row][col]; *, # and D are deliberately mapped to NONE.
    localparam logic [3:0][3:0][4:0] KEY_MAP = {
        {KEY_NONE,    KEY_NONE, 5'd0, KEY_NONE},
        {KEY_CONFIRM, 5'd9,     5'd8, 5'd7},
        {KEY_CLEAR,   5'd6,     5'd5, 5'd4},
        {KEY_START,   5'd3,     5'd2, 5'd1}
    };

    function automatic logic isDigit(input key_code_t code);
        return code <= 5'd9;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-rate debouncer: a key code must repeat for DEBOUNCE_FRAMES frames before it becomes stable.
module keypad_debounce
    import countdown_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEFAULT
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_frameValid,
    input  key_code_t i_frameCode,
    output key_code_t o_stable
);

    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEBOUNCE_FRAMES);

    key_code_t     r_cand;
    key_code_t     r_stable;
    logic [CW-1:0] r_count;
    key_code_t     w_candNext;
    logic [CW-1:0] w_countNext;

    always_comb begin
        w_candNext  = r_cand;
        w_countNext = r_count;
        if (i_frameValid) begin
            if (i_frameCode == r_cand) begin
                w_countNext = (r_count == COUNT_MAX) ? r_count : r_count + CW'(1);
            end else begin
                w_candNext  = i_frameCode;
                w_countNext = CW'(1);
            end
        end
    end

    // A direct key-to-key change is forced through NONE and the count restarts,
    // so the new key has to earn a complete debounce of its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand   <= KEY_NONE;
            r_stable <= KEY_NONE;
            r_count  <= '0;
        end else if (i_frameValid) begin
            r_cand  <= w_candNext;
            r_count <= w_countNext;
            if (w_countNext == COUNT_MAX && w_candNext != r_stable) begin
                if (r_stable == KEY_NONE || w_candNext == KEY_NONE) begin
                    r_stable <= w_candNext;
                end else begin
                    r_stable <= KEY_NONE;
                    r_count  <= '0;
                end
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, column synchronizer, per-frame decode and registered key events.
module keypad_scanner
    import countdown_pkg::*;
#(
    parameter int SCAN_DIV        = SCAN_DIV_DEFAULT,
    parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic       keydown_num,
    output logic       keydown_start,
    output logic       keydown_clear,
    output logic       keydown_confirm,
    output logic [3:0] num
);

    localparam int DW = $clog2(SCAN_DIV);

    logic [3:0]    r_colMeta;
    logic [3:0]    r_colSync;
    logic [DW-1:0] r_dwell;
    logic [1:0]    r_row;
    logic [3:0]    r_rowN;
    logic [1:0]    r_hits;
    key_code_t     r_hitCode;
    logic          r_kdNum;
    logic          r_kdStart;
    logic          r_kdClear;
    logic          r_kdConfirm;
    logic [3:0]    r_num;

    logic          w_dwellEnd;
    logic          w_frameValid;
    logic [2:0]    w_rowHits;
    logic [2:0]    w_totalHits;
    key_code_t     w_rowCode;
    key_code_t     w_frameCode;
    key_code_t     w_stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_colMeta <= 4'hF;
            r_colSync <= 4'hF;
        end else begin
            r_colMeta <= col_n;
            r_colSync <= r_colMeta;
        end
    end

    assign w_dwellEnd   = (r_dwell == DW'(SCAN_DIV - 1));
    assign w_frameValid = w_dwellEnd && (r_row == 2'd3);

    always_comb begin
        w_rowHits = 3'd0;
        w_rowCode = KEY_NONE;
        for (int c = 0; c < 4; c++) begin
            if (!r_colSync[c]) begin
                w_rowHits = w_rowHits + 3'd1;
                w_rowCode = KEY_MAP[r_row][c];
            end
        end
        w_totalHits = {1'b0, r_hits} + w_rowHits;
        w_frameCode = KEY_NONE;
        if (w_totalHits == 3'd1) begin
            w_frameCode = (r_hits == 2'd1) ? r_hitCode : w_rowCode;
        end
    end

    // Closures are accumulated across the four rows (saturating at two, which already
    // means "ghost/rollover"), then cleared as the frame result is handed to the debouncer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell   <= '0;
            r_row     <= 2'd0;
            r_rowN    <= 4'b1110;
            r_hits    <= 2'd0;
            r_hitCode <= KEY_NONE;
        end else if (w_dwellEnd) begin
            r_dwell <= '0;
            r_row   <= r_row + 2'd1;
            r_rowN  <= {r_rowN[2:0], r_rowN[3]};
            if (r_row == 2'd3) begin
                r_hits    <= 2'd0;
                r_hitCode <= KEY_NONE;
            end else begin
                r_hits <= (w_totalHits >= 3'd2) ? 2'd2 : w_totalHits[1:0];
                if (w_rowHits != 3'd0) begin
                    r_hitCode <= w_rowCode;
                end
            end
        end else begin
            r_dwell <= r_dwell + DW'(1);
        end
    end

    keypad_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_frameValid(w_frameValid),
        .i_frameCode (w_frameCode),
        .o_stable    (w_stable)
    );

    // num only reloads on a digit, so it keeps the last digit after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kdNum     <= 1'b0;
            r_kdStart   <= 1'b0;
            r_kdClear   <= 1'b0;
            r_kdConfirm <= 1'b0;
            r_num       <= 4'd0;
        end else begin
            r_kdNum     <= isDigit(w_stable);
            r_kdStart   <= (w_stable == KEY_START);
            r_kdClear   <= (w_stable == KEY_CLEAR);
            r_kdConfirm <= (w_stable == KEY_CONFIRM);
            if (isDigit(w_stable)) begin
                r_num <= w_stable[3:0];
            end
        end
    end

    assign row_n           = r_rowN;
    assign keydown_num     = r_kdNum;
    assign keydown_start   = r_kdStart;
    assign keydown_clear   = r_kdClear;
    assign keydown_confirm = r_kdConfirm;
    assign num             = r_num;

endmodule
